// File: rtl/lazy_select_pipeline_pkg.sv
// Shared types and constants for the lazy match-selection pipeline.
// The summary record is sized for the default configuration (LAZY_LEN=4, 8-bit lengths, 1K job, 16-bit offsets).
package lazy_select_pipeline_pkg;

    localparam int GAIN_W             = 32;
    localparam int LEN_WEIGHT_DEFAULT = 4;

    localparam int SUM_LL_W  = 11;
    localparam int SUM_ML_W  = 8;
    localparam int SUM_OFF_W = 16;
    localparam int SUM_MF_W  = 10;

    typedef struct packed {
        logic [SUM_LL_W-1:0]  ll;
        logic [SUM_ML_W-1:0]  ml;
        logic [SUM_OFF_W-1:0] offset;
        logic                 delim;
        logic                 eoj;
        logic [SUM_ML_W-1:0]  overlap_len;
        logic [SUM_MF_W-1:0]  move_forward;
        logic                 rep;
    } lazy_summary_t;

    function automatic int cost_width(input int offset_bits);
        return $clog2(offset_bits + 1);
    endfunction

endpackage

// File: rtl/lazy_select_pipeline_if.sv
// Handshake and data bundle for lazy_select_pipeline.
// slave is the pipeline's view; master is the view of whatever feeds and drains it.
interface lazy_select_pipeline_if #(
    parameter int LAZY_LEN        = 4,
    parameter int MATCH_LEN_WIDTH = 8,
    parameter int JOB_LEN_LOG2    = 10,
    parameter int OFFSET_BITS     = 16
);
    logic                                i_valid;
    logic                                i_ready;
    logic [JOB_LEN_LOG2-1:0]             i_match_head_ptr;
    logic [JOB_LEN_LOG2-1:0]             i_seq_head_ptr;
    logic                                i_delim;
    logic [LAZY_LEN-1:0]                 i_match_valid;
    logic [LAZY_LEN*MATCH_LEN_WIDTH-1:0] i_match_len;
    logic [LAZY_LEN*OFFSET_BITS-1:0]     i_offset;

    logic                                o_valid;
    logic                                o_ready;
    logic [JOB_LEN_LOG2-1:0]             o_seq_head_ptr;
    logic [JOB_LEN_LOG2:0]               o_ll;
    logic [MATCH_LEN_WIDTH-1:0]          o_ml;
    logic [OFFSET_BITS-1:0]              o_offset;
    logic                                o_delim;
    logic                                o_eoj;
    logic [MATCH_LEN_WIDTH-1:0]          o_overlap_len;
    logic                                o_move_to_next_job;
    logic [JOB_LEN_LOG2-1:0]             o_move_forward;
    logic                                o_rep;

    modport slave (
        input  i_valid, i_match_head_ptr, i_seq_head_ptr, i_delim,
               i_match_valid, i_match_len, i_offset, o_ready,
        output i_ready, o_valid, o_seq_head_ptr, o_ll, o_ml, o_offset,
               o_delim, o_eoj, o_overlap_len, o_move_to_next_job,
               o_move_forward, o_rep
    );

    modport master (
        output i_valid, i_match_head_ptr, i_seq_head_ptr, i_delim,
               i_match_valid, i_match_len, i_offset, o_ready,
        input  i_ready, o_valid, o_seq_head_ptr, o_ll, o_ml, o_offset,
               o_delim, o_eoj, o_overlap_len, o_move_to_next_job,
               o_move_forward, o_rep
    );

endinterface

// File: rtl/lazy_select_pipeline_offset_cost_enc.sv
// Offset cost encoder: position of the most significant set bit plus one, zero for a zero offset.
module offset_cost_enc #(
    parameter int OFFSET_BITS = 16,
    parameter int COST_W      = $clog2(OFFSET_BITS + 1)
) (
    input  logic [OFFSET_BITS-1:0] i_offset,
    output logic [COST_W-1:0]      o_cost
);

    always_comb begin
        // NOTE: every always_comb output gets a default before any condition, so no latch can be inferred.
        o_cost = '0;
        for (int i = 0; i < OFFSET_BITS; i++) begin
            if (i_offset[i]) o_cost = COST_W'(i + 1);
        end
    end

endmodule

// File: rtl/lazy_select_pipeline.sv
// Four-stage lazy match selector: S0 ll/cost, S1 gain/move_forward, S2 best pick, S3 end-of-job split.
// Optional repeat-offset tracking is enabled with the LAZY_REP_OFFSET_EN macro.
module lazy_select_pipeline
    import lazy_select_pipeline_pkg::*;
#(
    parameter int LAZY_LEN        = 4,
    parameter int MATCH_LEN_WIDTH = 8,
    parameter int JOB_LEN_LOG2    = 10,
    parameter int OFFSET_BITS     = 16,
    parameter int LEN_WEIGHT      = LEN_WEIGHT_DEFAULT
) (
    input logic                   clk,
    input logic                   rst_n,
    lazy_select_pipeline_if.slave bus
);

    localparam int J    = JOB_LEN_LOG2;
    localparam int LLW  = J + 1;
    localparam int MW   = MATCH_LEN_WIDTH;
    localparam int OW   = OFFSET_BITS;
    localparam int CW   = $clog2(OW + 1);
    localparam int MFW  = MW + 1;
    localparam int MFSW = (MFW > J) ? MFW : J;
    localparam int OVW  = MFSW + 2;

    logic                      r_s0_valid, r_s1_valid, r_s2_valid, r_s3_valid;
    logic [LAZY_LEN-1:0]       r_s0_cand_valid, r_s1_cand_valid;
    logic [MW-1:0]             r_s0_ml [LAZY_LEN];
    logic [MW-1:0]             r_s1_ml [LAZY_LEN];
    logic [OW-1:0]             r_s0_off [LAZY_LEN];
    logic [OW-1:0]             r_s1_off [LAZY_LEN];
    logic [J-1:0]              r_s0_ll [LAZY_LEN];
    logic [J-1:0]              r_s1_ll [LAZY_LEN];
    logic [CW-1:0]             r_s0_cost [LAZY_LEN];
    logic signed [GAIN_W-1:0]  r_s1_gain [LAZY_LEN];
    logic [MFW-1:0]            r_s1_mf [LAZY_LEN];
    logic [J-1:0]              r_s0_seq, r_s1_seq, r_s2_seq;
    logic                      r_s0_delim, r_s1_delim, r_s2_delim;
    logic [J-1:0]              r_s2_ll;
    logic [MW-1:0]             r_s2_ml;
    logic [OW-1:0]             r_s2_off;
    logic [MFSW-1:0]           r_s2_mf;
    logic                      r_s2_rep;
`ifdef LAZY_REP_OFFSET_EN
    logic [CW-1:0]             r_s1_cost [LAZY_LEN];
    logic [OW-1:0]             r_rep_offset;
`endif

    logic                      w_en;
    logic [MW-1:0]             w_in_ml [LAZY_LEN];
    logic [OW-1:0]             w_in_off [LAZY_LEN];
    logic [J-1:0]              w_in_ll [LAZY_LEN];
    logic [CW-1:0]             w_in_cost [LAZY_LEN];
    logic signed [GAIN_W-1:0]  w_s1_gain [LAZY_LEN];
    logic [MFW-1:0]            w_s1_mf [LAZY_LEN];
    logic [J-1:0]              w_sel_ll;
    logic [MW-1:0]             w_sel_ml;
    logic [OW-1:0]             w_sel_off;
    logic [MFSW-1:0]           w_sel_mf;
    logic                      w_sel_rep;
    logic [OVW-1:0]            w_overlap;
    logic                      w_s3_eoj;
    logic [LLW-1:0]            w_s3_ll;
    logic [MW-1:0]             w_s3_ml, w_s3_ovl;
    logic [OW-1:0]             w_s3_off;
    logic [J-1:0]              w_s3_mf;
    logic                      w_s3_rep;

    assign w_en        = ~r_s3_valid | bus.o_ready;
    assign bus.i_ready = w_en;

    for (genvar g = 0; g < LAZY_LEN; g++) begin : g_cand
        assign w_in_ml[g]  = bus.i_match_len[g*MW +: MW];
        assign w_in_off[g] = bus.i_offset[g*OW +: OW];
        assign w_in_ll[g]  = bus.i_match_head_ptr - bus.i_seq_head_ptr + J'(g);

        offset_cost_enc #(.OFFSET_BITS(OW), .COST_W(CW)) u_cost (
            .i_offset (w_in_off[g]),
            .o_cost   (w_in_cost[g])
        );
    end

    // S0: literal lengths and offset costs per candidate.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is only ever assigned with <=, so every stage samples the pre-edge values.
        if (!rst_n) begin
            r_s0_valid      <= 1'b0;
            r_s0_cand_valid <= '0;
            r_s0_seq        <= '0;
            r_s0_delim      <= 1'b0;
            // NOTE: these per-candidate arrays are pipeline flops, not RAM, so resetting them is cheap and keeps outputs deterministic.
            for (int i = 0; i < LAZY_LEN; i++) begin
                r_s0_ml[i]   <= '0;
                r_s0_off[i]  <= '0;
                r_s0_ll[i]   <= '0;
                r_s0_cost[i] <= '0;
            end
        end else if (w_en) begin
            r_s0_valid      <= bus.i_valid;
            r_s0_cand_valid <= bus.i_match_valid;
            r_s0_seq        <= bus.i_seq_head_ptr;
            r_s0_delim      <= bus.i_delim;
            for (int i = 0; i < LAZY_LEN; i++) begin
                r_s0_ml[i]   <= w_in_ml[i];
                r_s0_off[i]  <= w_in_off[i];
                r_s0_ll[i]   <= w_in_ll[i];
                r_s0_cost[i] <= w_in_cost[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < LAZY_LEN; i++) begin
            w_s1_gain[i] = GAIN_W'(LEN_WEIGHT) * GAIN_W'(r_s0_ml[i])
                         + GAIN_W'(LEN_WEIGHT) * GAIN_W'(LAZY_LEN - i)
                         - GAIN_W'(r_s0_cost[i]);
            w_s1_mf[i]   = MFW'(r_s0_ml[i]) + MFW'(r_s0_ll[i]);
        end
    end

    // S1: gain and move_forward per candidate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid      <= 1'b0;
            r_s1_cand_valid <= '0;
            r_s1_seq        <= '0;
            r_s1_delim      <= 1'b0;
            for (int i = 0; i < LAZY_LEN; i++) begin
                r_s1_ml[i]   <= '0;
                r_s1_off[i]  <= '0;
                r_s1_ll[i]   <= '0;
                r_s1_gain[i] <= '0;
                r_s1_mf[i]   <= '0;
`ifdef LAZY_REP_OFFSET_EN
                r_s1_cost[i] <= '0;
`endif
            end
        end else if (w_en) begin
            r_s1_valid      <= r_s0_valid;
            r_s1_cand_valid <= r_s0_cand_valid;
            r_s1_seq        <= r_s0_seq;
            r_s1_delim      <= r_s0_delim;
            for (int i = 0; i < LAZY_LEN; i++) begin
                r_s1_ml[i]   <= r_s0_ml[i];
                r_s1_off[i]  <= r_s0_off[i];
                r_s1_ll[i]   <= r_s0_ll[i];
                r_s1_gain[i] <= w_s1_gain[i];
                r_s1_mf[i]   <= w_s1_mf[i];
`ifdef LAZY_REP_OFFSET_EN
                r_s1_cost[i] <= r_s0_cost[i];
`endif
            end
        end
    end

    // Strict > keeps the lowest index on a tie; with no valid candidate only literals remain.
    always_comb begin
        logic                     v_found;
        logic signed [GAIN_W-1:0] v_best;
        logic signed [GAIN_W-1:0] v_gain;
        v_found   = 1'b0;
        v_best    = '0;
        v_gain    = '0;
        w_sel_ll  = r_s1_ll[0];
        w_sel_ml  = '0;
        w_sel_off = '0;
        w_sel_mf  = MFSW'(r_s1_ll[0]);
        for (int i = 0; i < LAZY_LEN; i++) begin
            v_gain = r_s1_gain[i];
`ifdef LAZY_REP_OFFSET_EN
            if (r_rep_offset != '0 && r_s1_off[i] == r_rep_offset)
                v_gain = r_s1_gain[i] + GAIN_W'(r_s1_cost[i]) - GAIN_W'(1);
`endif
            if (r_s1_cand_valid[i] && (!v_found || v_gain > v_best)) begin
                v_found   = 1'b1;
                v_best    = v_gain;
                w_sel_ll  = r_s1_ll[i];
                w_sel_ml  = r_s1_ml[i];
                w_sel_off = r_s1_off[i];
                w_sel_mf  = MFSW'(r_s1_mf[i]);
            end
        end
    end

`ifdef LAZY_REP_OFFSET_EN
    assign w_sel_rep = (r_rep_offset != '0) && (w_sel_off == r_rep_offset);
`else
    assign w_sel_rep = 1'b0;
`endif

    // S2: the selected candidate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_seq   <= '0;
            r_s2_delim <= 1'b0;
            r_s2_ll    <= '0;
            r_s2_ml    <= '0;
            r_s2_off   <= '0;
            r_s2_mf    <= '0;
            r_s2_rep   <= 1'b0;
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            r_s2_seq   <= r_s1_seq;
            r_s2_delim <= r_s1_delim;
            r_s2_ll    <= w_sel_ll;
            r_s2_ml    <= w_sel_ml;
            r_s2_off   <= w_sel_off;
            r_s2_mf    <= w_sel_mf;
            r_s2_rep   <= w_sel_rep;
        end
    end

    // A non-negative overlap means this record reaches or crosses the end of the job window.
    assign w_overlap = OVW'(r_s2_mf) + OVW'(r_s2_seq) - OVW'(2 ** J);
    assign w_s3_eoj  = ~w_overlap[OVW-1];

    always_comb begin
        w_s3_ll  = LLW'(r_s2_ll);
        w_s3_ml  = r_s2_ml;
        w_s3_off = r_s2_off;
        w_s3_ovl = '0;
        w_s3_mf  = r_s2_mf[J-1:0];
        w_s3_rep = r_s2_rep;
        if (w_s3_eoj) begin
            w_s3_mf = '0;
            if (r_s2_delim) begin
                w_s3_ll  = LLW'(2 ** J) - LLW'(r_s2_seq);
                w_s3_ml  = '0;
                w_s3_off = '0;
                w_s3_rep = 1'b0;
            end else begin
                w_s3_ovl = w_overlap[MW-1:0];
            end
        end
    end

`ifdef LAZY_REP_OFFSET_EN
    // A newer selection wins over an older record's end-of-job clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_offset <= '0;
        end else if (w_en) begin
            if (r_s1_valid && w_sel_ml != '0)
                r_rep_offset <= w_sel_off;
            else if (r_s2_valid && w_s3_eoj && r_s2_delim)
                r_rep_offset <= '0;
        end
    end
`endif

    // S3: output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s3_valid             <= 1'b0;
            bus.o_seq_head_ptr     <= '0;
            bus.o_ll               <= '0;
            bus.o_ml               <= '0;
            bus.o_offset           <= '0;
            bus.o_delim            <= 1'b0;
            bus.o_eoj              <= 1'b0;
            bus.o_overlap_len      <= '0;
            bus.o_move_to_next_job <= 1'b0;
            bus.o_move_forward     <= '0;
            bus.o_rep              <= 1'b0;
        end else if (w_en) begin
            r_s3_valid             <= r_s2_valid;
            bus.o_seq_head_ptr     <= r_s2_seq;
            bus.o_ll               <= w_s3_ll;
            bus.o_ml               <= w_s3_ml;
            bus.o_offset           <= w_s3_off;
            bus.o_delim            <= r_s2_delim;
            bus.o_eoj              <= w_s3_eoj;
            bus.o_overlap_len      <= w_s3_ovl;
            bus.o_move_to_next_job <= w_s3_eoj;
            bus.o_move_forward     <= w_s3_mf;
            bus.o_rep              <= w_s3_rep;
        end
    end

    assign bus.o_valid = r_s3_valid;

endmodule

// File: tb/tb_lazy_select_pipeline.sv
// Self-checking bench for lazy_select_pipeline: directed cases plus a randomized stream
// scored against a behavioural model of the selection rules.
module tb_lazy_select_pipeline;
    import lazy_select_pipeline_pkg::*;

    localparam int LL = 4;
    localparam int MW = 8;
    localparam int J  = 10;
    localparam int OW = 16;

    typedef struct {
        int       head;
        int       seq;
        bit       delim;
        bit [3:0] v;
        int       ml [LL];
        int       off [LL];
    } in_rec_t;

    typedef struct {
        lazy_summary_t s;
        int            seq;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    lazy_select_pipeline_if #(.LAZY_LEN(LL), .MATCH_LEN_WIDTH(MW), .JOB_LEN_LOG2(J), .OFFSET_BITS(OW)) bus ();

    lazy_select_pipeline #(
        .LAZY_LEN(LL), .MATCH_LEN_WIDTH(MW), .JOB_LEN_LOG2(J), .OFFSET_BITS(OW), .LEN_WEIGHT(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   checks  = 0;
    int   errors  = 0;
    int   emitted = 0;
    int   ready_mode = 0;
    exp_t exp_q[$];
    logic last_rep;
    int   last_off;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: gain = 4*ml + 4*(LL-i) - (floor(log2(off))+1), best = strictly greatest valid gain.
    function automatic lazy_summary_t model(input in_rec_t r);
        lazy_summary_t s;
        int best, bg, g, cost, llb, ml, off, mf, ov;
        best = -1;
        bg   = 0;
        for (int i = 0; i < LL; i++) begin
            cost = (r.off[i] == 0) ? 0 : $clog2(r.off[i] + 1);
            g    = 4 * r.ml[i] + 4 * (LL - i) - cost;
            if (r.v[i] && (best < 0 || g > bg)) begin
                best = i;
                bg   = g;
            end
        end
        s = '0;
        if (best < 0) begin
            llb = (r.head - r.seq) & ((1 << J) - 1);
            ml  = 0;
            off = 0;
            mf  = llb;
        end else begin
            llb = (r.head - r.seq + best) & ((1 << J) - 1);
            ml  = r.ml[best];
            off = r.off[best];
            mf  = (ml + llb) % 512;
        end
        ov      = mf + r.seq - (1 << J);
        s.delim = r.delim;
        if (ov >= 0) begin
            s.eoj = 1'b1;
            if (r.delim) begin
                s.ll = 11'((1 << J) - r.seq);
            end else begin
                s.ll          = 11'(llb);
                s.ml          = 8'(ml);
                s.offset      = 16'(off);
                s.overlap_len = 8'(ov);
            end
        end else begin
            s.ll           = 11'(llb);
            s.ml           = 8'(ml);
            s.offset       = 16'(off);
            s.move_forward = 10'(mf);
        end
        return s;
    endfunction

    function automatic in_rec_t blank_rec();
        in_rec_t r;
        r.head  = 0;
        r.seq   = 0;
        r.delim = 1'b0;
        r.v     = '0;
        for (int i = 0; i < LL; i++) begin
            r.ml[i]  = 0;
            r.off[i] = 0;
        end
        return r;
    endfunction

    function automatic in_rec_t rand_rec();
        in_rec_t r;
        r.seq   = int'($urandom_range(1023));
        r.head  = (r.seq + int'($urandom_range(200))) & 1023;
        r.delim = ($urandom_range(3) == 0);
        r.v     = 4'($urandom_range(15));
        for (int i = 0; i < LL; i++) begin
            r.ml[i] = int'($urandom_range(255));
            case ($urandom_range(3))
                0:       r.off[i] = 0;
                1:       r.off[i] = 1 << $urandom_range(15);
                2:       r.off[i] = int'($urandom_range(65535));
                default: r.off[i] = int'($urandom_range(7));
            endcase
        end
        if ($urandom_range(3) == 0) begin
            r.ml[1]  = r.ml[0] + 1;
            r.off[1] = r.off[0];
        end
        return r;
    endfunction

    function automatic in_rec_t simple_rec(input int k);
        in_rec_t r;
        r        = blank_rec();
        r.seq    = 100 + 3 * k;
        r.head   = r.seq + k;
        r.v      = 4'b0001;
        r.ml[0]  = k + 1;
        r.off[0] = 16 * k + 1;
        return r;
    endfunction

    task automatic drive(input in_rec_t r);
        bus.i_match_head_ptr = 10'(r.head);
        bus.i_seq_head_ptr   = 10'(r.seq);
        bus.i_delim          = r.delim;
        bus.i_match_valid    = r.v;
        for (int i = 0; i < LL; i++) begin
            bus.i_match_len[i*MW +: MW] = 8'(r.ml[i]);
            bus.i_offset[i*OW +: OW]    = 16'(r.off[i]);
        end
    endtask

    task automatic send(input in_rec_t r);
        bit   done;
        exp_t e;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            drive(r);
            bus.i_valid = 1'b1;
            #1;
            if (bus.i_ready) begin
                @(posedge clk);
                e.s   = model(r);
                e.seq = r.seq;
                exp_q.push_back(e);
                done = 1'b1;
                #1 bus.i_valid = 1'b0;
            end
        end
        bus.i_valid = 1'b0;
        check("send_accepted", 64'(done), 64'(1));
    endtask

    task automatic drain();
        for (int n = 0; n < 500 && exp_q.size() > 0; n++) @(negedge clk);
        #2;
        check("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        bus.o_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       bus.o_ready = 1'b1;
                1:       bus.o_ready = ($urandom_range(3) != 0);
                default: bus.o_ready = 1'b0;
            endcase
        end
    end

    // Scoreboard: every output transfer must match the oldest outstanding expectation.
    initial begin
        lazy_summary_t a;
        exp_t          e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                check("reset_o_valid", 64'(bus.o_valid), 64'(0));
            end else if (bus.o_valid && bus.o_ready) begin
                check("expected_pending", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    e             = exp_q.pop_front();
                    a             = '0;
                    a.ll          = bus.o_ll;
                    a.ml          = bus.o_ml;
                    a.offset      = bus.o_offset;
                    a.delim       = bus.o_delim;
                    a.eoj         = bus.o_eoj;
                    a.overlap_len = bus.o_overlap_len;
                    a.move_forward = bus.o_move_forward;
`ifdef LAZY_REP_OFFSET_EN
                    a.rep         = 1'b0;
`else
                    a.rep         = bus.o_rep;
`endif
                    check("record", 64'(a), 64'(e.s));
                    check("seq_head_ptr", 64'(bus.o_seq_head_ptr), 64'(e.seq));
                    check("move_to_next_job", 64'(bus.o_move_to_next_job), 64'(e.s.eoj));
                    last_rep = bus.o_rep;
                    last_off = int'(bus.o_offset);
                    emitted++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        in_rec_t       r;
        lazy_summary_t m;
        int            lat, base;
        bit            seen;
        logic [63:0]   snap;

        bus.i_valid = 1'b0;
        drive(blank_rec());
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_o_valid", 64'(bus.o_valid), 64'(0));
        check("rst_i_ready", 64'(bus.i_ready), 64'(1));
        check("rst_o_ll", 64'(bus.o_ll), 64'(0));
        check("rst_o_rep", 64'(bus.o_rep), 64'(0));

        // Single record: best is candidate 1 (gain 27 vs 23).
        r        = blank_rec();
        r.head   = 10;
        r.seq    = 8;
        r.v      = 4'b0011;
        r.ml[0]  = 4;
        r.ml[1]  = 6;
        r.off[0] = 256;
        r.off[1] = 256;
        m = model(r);
        check("model_single_ll", 64'(m.ll), 64'(3));
        check("model_single_ml", 64'(m.ml), 64'(6));
        check("model_single_mf", 64'(m.move_forward), 64'(9));
        send(r);
        lat  = 0;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            #1;
            lat++;
            seen = bus.o_valid;
        end
        check("latency", 64'(lat), 64'(4));
        check("single_o_ll", 64'(bus.o_ll), 64'(3));
        check("single_o_ml", 64'(bus.o_ml), 64'(6));
        check("single_o_offset", 64'(bus.o_offset), 64'(256));
        check("single_o_move_forward", 64'(bus.o_move_forward), 64'(9));
        check("single_o_eoj", 64'(bus.o_eoj), 64'(0));
        drain();

        // Tie: gains 35 and 35, lowest index wins.
        r        = blank_rec();
        r.head   = 20;
        r.seq    = 20;
        r.v      = 4'b0011;
        r.ml[0]  = 5;
        r.ml[1]  = 6;
        r.off[0] = 1;
        r.off[1] = 1;
        m = model(r);
        check("model_tie_ml", 64'(m.ml), 64'(5));
        send(r);
        drain();

        // End of job, with and without delimiter.
        r        = blank_rec();
        r.head   = 1000;
        r.seq    = 1000;
        r.v      = 4'b0001;
        r.ml[0]  = 30;
        r.off[0] = 1;
        m = model(r);
        check("model_eoj_overlap", 64'(m.overlap_len), 64'(6));
        check("model_eoj_flag", 64'(m.eoj), 64'(1));
        send(r);
        r.delim = 1'b1;
        m = model(r);
        check("model_eoj_delim_ll", 64'(m.ll), 64'(24));
        check("model_eoj_delim_ml", 64'(m.ml), 64'(0));
        send(r);
        drain();

        // Backpressure: 8 records streamed while the output is stalled for 5 cycles.
        base       = emitted;
        ready_mode = 0;
        fork
            begin
                for (int k = 0; k < 8; k++) send(simple_rec(k));
            end
            begin
                for (int n = 0; n < 50 && !bus.o_valid; n++) begin
                    @(negedge clk);
                    #1;
                end
                ready_mode = 2;
                @(negedge clk);
                #1;
                snap = {bus.o_valid, 11'(bus.o_ll), bus.o_ml, bus.o_offset, 10'(bus.o_seq_head_ptr)};
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    #1;
                    check("bp_i_ready", 64'(bus.i_ready), 64'(0));
                    check("bp_hold", {bus.o_valid, 11'(bus.o_ll), bus.o_ml, bus.o_offset, 10'(bus.o_seq_head_ptr)}, snap);
                end
                ready_mode = 0;
            end
        join
        drain();
        check("bp_count", 64'(emitted - base), 64'(8));

        // Reset with three records in flight.
        base = emitted;
        for (int k = 0; k < 3; k++) send(simple_rec(k + 10));
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_o_valid", 64'(bus.o_valid), 64'(0));
        check("midrst_i_ready", 64'(bus.i_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #2;
        check("midrst_no_stale", 64'(emitted - base), 64'(0));

`ifdef LAZY_REP_OFFSET_EN
        r        = blank_rec();
        r.v      = 4'b0001;
        r.ml[0]  = 10;
        r.off[0] = 4096;
        send(r);
        r.v      = 4'b0011;
        r.ml[0]  = 8;
        r.ml[1]  = 9;
        r.off[1] = 65535;
        send(r);
        drain();
        check("rep_offset", 64'(last_off), 64'(4096));
        check("rep_flag", 64'(last_rep), 64'(1));
`else
        // Randomized stream with bubbles and random output stalls.
        ready_mode = 1;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(4) == 0) @(negedge clk);
            send(rand_rec());
        end
        ready_mode = 0;
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
